comms_link_rx: RTL and testbench

Receive-side deframer for the inter-board 8-pin link. Synchronises the raw link pins (pin 0 = link clock, pins 7:1 = half-select + 6-bit payload) and samples each symbol at a fixed delay after the link-clock rising edge. Pairs high/low halves into a 12-bit word with a one-cycle valid strobe, and reports link health (link-up, error count). Sits directly downstream of the link transmitter on the partner board; it feeds the keyboard/health data consumers.

---
 rtl/comms_link_rx.sv | 197 +++++++++++++++++++
 tb/tb_comms_link_rx.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/comms_link_rx.sv
// comms_link_rx: receive-side deframer for the inter-board 8-pin link.
// Synchronises the raw pins, samples each symbol a fixed delay after the
// link-clock rising edge, pairs high/low halves into a 12-bit word and
// reports link health (link-up, saturating framing-error count).
// Optional build macro: COMMS_RX_MAJORITY_EN -- 2-of-3 majority sampling
// around the sample point (FRAME and word_valid move one cycle later).
module comms_link_rx #(
   parameter int SAMPLE_DELAY = 50000,
   parameter int TIMEOUT      = 300000,
   parameter int ERR_W        = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [7:0]       rx_pins,
   output logic [11:0]      word,
   output logic             word_valid,
   output logic             link_up,
   output logic [ERR_W-1:0] err_count
);

   localparam int CNT_W  = $clog2(SAMPLE_DELAY + 2) + 1;
   localparam int IDLE_W = $clog2(TIMEOUT + 1) + 1;

   localparam logic [CNT_W-1:0]  SAMPLE_CNT = CNT_W'(SAMPLE_DELAY);
   localparam logic [IDLE_W-1:0] IDLE_MAX   = IDLE_W'(TIMEOUT);
   localparam logic [IDLE_W-1:0] IDLE_LAST  = IDLE_W'(TIMEOUT - 1);
`ifdef COMMS_RX_MAJORITY_EN
   localparam logic [CNT_W-1:0]  FIRST_CNT  = CNT_W'(SAMPLE_DELAY - 1);
   localparam logic [CNT_W-1:0]  LAST_CNT   = CNT_W'(SAMPLE_DELAY + 1);
`else
   localparam logic [CNT_W-1:0]  LAST_CNT   = CNT_W'(SAMPLE_DELAY);
`endif

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_FRAME
   } state_e;

   logic [7:0]       sync1_q, sync1_d, sync2_q, sync2_d;
   logic             pin0_prev_q, pin0_prev_d;
   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [IDLE_W-1:0] idle_q, idle_d;
   logic [6:0]       sym_q, sym_d;
   logic [5:0]       hi_q, hi_d;
   logic             hi_pending_q, hi_pending_d;
   logic [11:0]      word_q, word_d;
   logic             word_valid_q, word_valid_d;
   logic             link_up_q, link_up_d;
   logic [ERR_W-1:0] err_q, err_d;
`ifdef COMMS_RX_MAJORITY_EN
   logic [6:0]       samp_a_q, samp_a_d, samp_b_q, samp_b_d;
`endif

   logic edge_det;
   logic expire;
   logic err_inc;

   assign edge_det = sync2_q[0] & ~pin0_prev_q;

   // Next-state logic: synchroniser, idle timer, deframing FSM, health.
   always_comb begin
      // NOTE: every signal gets a default before any branch so no path leaves
      // it unassigned; that is what keeps this block free of inferred latches.
      sync1_d      = rx_pins;
      sync2_d      = sync1_q;
      pin0_prev_d  = sync2_q[0];
      state_d      = state_q;
      cnt_d        = cnt_q;
      idle_d       = idle_q;
      sym_d        = sym_q;
      hi_d         = hi_q;
      hi_pending_d = hi_pending_q;
      word_d       = word_q;
      word_valid_d = 1'b0;
      link_up_d    = link_up_q;
      err_d        = err_q;
      err_inc      = 1'b0;
`ifdef COMMS_RX_MAJORITY_EN
      samp_a_d     = samp_a_q;
      samp_b_d     = samp_b_q;
`endif

      // Idle timer: an edge always wins over a same-cycle expiry.
      expire = 1'b0;
      if (edge_det) begin
         idle_d = '0;
      end else if (idle_q != IDLE_MAX) begin
         idle_d = idle_q + 1'b1;
         expire = (idle_q == IDLE_LAST);
      end
      if (expire) begin
         link_up_d    = 1'b0;
         hi_pending_d = 1'b0;
      end

      // FRAME actions come after the timeout so a completing word wins.
      unique case (state_q)
         ST_IDLE: begin
            if (edge_det) begin
               state_d = ST_WAIT;
               cnt_d   = '0;
            end
         end
         ST_WAIT: begin
            if (edge_det) begin
               cnt_d   = '0;
               err_inc = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
`ifdef COMMS_RX_MAJORITY_EN
               if (cnt_q == FIRST_CNT) samp_a_d = sync2_q[7:1];
               if (cnt_q == SAMPLE_CNT) samp_b_d = sync2_q[7:1];
               if (cnt_q == LAST_CNT) begin
                  sym_d   = (samp_a_q & samp_b_q) | (samp_a_q & sync2_q[7:1]) |
                            (samp_b_q & sync2_q[7:1]);
                  state_d = ST_FRAME;
               end
`else
               if (cnt_q == LAST_CNT) begin
                  sym_d   = sync2_q[7:1];
                  state_d = ST_FRAME;
               end
`endif
            end
         end
         ST_FRAME: begin
            state_d = ST_IDLE;
            if (!sym_q[6]) begin
               hi_d         = sym_q[5:0];
               hi_pending_d = 1'b1;
               err_inc      = hi_pending_q;
            end else if (hi_pending_q) begin
               word_d       = {hi_q, sym_q[5:0]};
               word_valid_d = 1'b1;
               hi_pending_d = 1'b0;
               link_up_d    = 1'b1;
            end else begin
               err_inc = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (err_inc && (err_q != {ERR_W{1'b1}})) err_d = err_q + 1'b1;
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // flop samples the pre-edge value of every other flop.
      if (!rst_n) begin
         sync1_q      <= '0;
         sync2_q      <= '0;
         pin0_prev_q  <= 1'b0;
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         idle_q       <= '0;
         sym_q        <= '0;
         hi_q         <= '0;
         hi_pending_q <= 1'b0;
         word_q       <= '0;
         word_valid_q <= 1'b0;
         link_up_q    <= 1'b0;
         err_q        <= '0;
`ifdef COMMS_RX_MAJORITY_EN
         samp_a_q     <= '0;
         samp_b_q     <= '0;
`endif
      end else begin
         sync1_q      <= sync1_d;
         sync2_q      <= sync2_d;
         pin0_prev_q  <= pin0_prev_d;
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         idle_q       <= idle_d;
         sym_q        <= sym_d;
         hi_q         <= hi_d;
         hi_pending_q <= hi_pending_d;
         word_q       <= word_d;
         word_valid_q <= word_valid_d;
         link_up_q    <= link_up_d;
         err_q        <= err_d;
`ifdef COMMS_RX_MAJORITY_EN
         samp_a_q     <= samp_a_d;
         samp_b_q     <= samp_b_d;
`endif
      end
   end

   assign word       = word_q;
   assign word_valid = word_valid_q;
   assign link_up    = link_up_q;
   assign err_count  = err_q;

endmodule

// File: tb/tb_comms_link_rx.sv
// Directed testbench for comms_link_rx: SAMPLE_DELAY=8, TIMEOUT=60, a
// 2-bit error counter so saturation is reachable, link period ~20 cycles.
module tb_comms_link_rx;

   localparam int SD = 8;
   localparam int TO = 60;
   localparam int EW = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [7:0]    rx_pins;
   logic [11:0]   word;
   logic          word_valid;
   logic          link_up;
   logic [EW-1:0] err_count;

   int checks = 0;
   int errors = 0;
   int vcount = 0;
   int dbl    = 0;
   int v0;
   logic prev_wv = 1'b0;
   logic [11:0] glitch_exp;

   comms_link_rx #(.SAMPLE_DELAY(SD), .TIMEOUT(TO), .ERR_W(EW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx_pins    (rx_pins),
      .word       (word),
      .word_valid (word_valid),
      .link_up    (link_up),
      .err_count  (err_count)
   );

   always #5 clk = ~clk;

   // Count word_valid pulses and back-to-back pulses, away from the active edge.
   always @(negedge clk) begin
      if (word_valid) vcount++;
      if (word_valid && prev_wv) dbl++;
      prev_wv <= word_valid;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One link period: pin0 high for 10 cycles, low for 10, payload held.
   task automatic send_sym(input logic [6:0] s);
      @(negedge clk);
      rx_pins = {s, 1'b1};
      repeat (10) @(negedge clk);
      rx_pins = {s, 1'b0};
      repeat (10) @(negedge clk);
   endtask

   // Same as send_sym but payload bit 3 (pin 4) is flipped for the single
   // raw cycle that lands on the middle sample point.
   task automatic send_glitch(input logic [6:0] s);
      @(negedge clk);
      rx_pins = {s, 1'b1};
      repeat (SD + 1) @(negedge clk);
      rx_pins[4] = ~rx_pins[4];
      @(negedge clk);
      rx_pins = {s, 1'b0};
      repeat (10) @(negedge clk);
   endtask

   initial begin
`ifdef COMMS_RX_MAJORITY_EN
      glitch_exp = 12'hA80;
`else
      glitch_exp = 12'hA88;
`endif
      rx_pins = 8'h00;
      rst_n   = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_word", word, 12'h000);
      check("rst_valid", word_valid, 1'b0);
      check("rst_link", link_up, 1'b0);
      check("rst_err", err_count, 2'd0);
      rst_n = 1'b1;

      // Normal pair.
      v0 = vcount;
      send_sym({1'b0, 6'h2A});
      check("pair_link_before", link_up, 1'b0);
      send_sym({1'b1, 6'h15});
      check("pair_word", word, 12'hA95);
      check("pair_pulses", vcount - v0, 1);
      check("pair_link", link_up, 1'b1);
      check("pair_err", err_count, 2'd0);
      repeat (20) @(negedge clk);
      check("link_held", link_up, 1'b1);

      // Orphan low, then a good pair.
      v0 = vcount;
      send_sym({1'b1, 6'h01});
      check("orphan_err", err_count, 2'd1);
      check("orphan_nopulse", vcount - v0, 0);
      check("orphan_word", word, 12'hA95);
      send_sym({1'b0, 6'h3F});
      send_sym({1'b1, 6'h00});
      check("pair2_word", word, 12'hFC0);
      check("pair2_err", err_count, 2'd1);
      check("pair2_pulses", vcount - v0, 1);

      // Double high half overwrites.
      send_sym({1'b0, 6'h11});
      send_sym({1'b0, 6'h22});
      check("dbl_hi_err", err_count, 2'd2);
      send_sym({1'b1, 6'h33});
      check("dbl_hi_word", word, 12'h8B3);

      // Timeout with a pending high half; the following low half is orphaned.
      send_sym({1'b0, 6'h05});
      check("pre_timeout_link", link_up, 1'b1);
      repeat (TO) @(negedge clk);
      check("timeout_link", link_up, 1'b0);
      check("timeout_word", word, 12'h8B3);
      v0 = vcount;
      send_sym({1'b1, 6'h07});
      check("post_to_err", err_count, 2'd3);
      check("post_to_nopulse", vcount - v0, 0);
      check("post_to_word", word, 12'h8B3);
      send_sym({1'b1, 6'h07});
      check("err_saturate", err_count, 2'd3);

      // Single-cycle glitch on bit 3 at the middle sample point.
      send_sym({1'b0, 6'h2A});
      send_glitch({1'b1, 6'h00});
      check("glitch_word", word, glitch_exp);
      check("glitch_link", link_up, 1'b1);

      // Reset in the middle of WAIT for a low half.
      send_sym({1'b0, 6'h12});
      v0 = vcount;
      @(negedge clk);
      rx_pins = {1'b1, 6'h0F, 1'b1};
      repeat (4) @(negedge clk);
      rx_pins[0] = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("midrst_word", word, 12'h000);
      check("midrst_valid", word_valid, 1'b0);
      check("midrst_link", link_up, 1'b0);
      check("midrst_err", err_count, 2'd0);
      repeat (20) @(negedge clk);
      check("midrst_nopulse", vcount - v0, 0);
      send_sym({1'b1, 6'h3C});
      check("midrst_orphan_err", err_count, 2'd1);
      check("midrst_orphan_word", word, 12'h000);

      // Second link-clock edge while in WAIT restarts the sample count.
      @(negedge clk);
      rx_pins = {1'b0, 6'h0A, 1'b1};
      repeat (2) @(negedge clk);
      rx_pins[0] = 1'b0;
      repeat (2) @(negedge clk);
      rx_pins[0] = 1'b1;
      repeat (10) @(negedge clk);
      rx_pins[0] = 1'b0;
      repeat (12) @(negedge clk);
      check("wait_edge_err", err_count, 2'd2);
      v0 = vcount;
      send_sym({1'b1, 6'h01});
      check("wait_edge_word", word, 12'h281);
      check("wait_edge_pulses", vcount - v0, 1);

      check("no_back_to_back", dbl, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
